// File: rtl/pll_ce_pkg.sv
// pll_ce_pkg: shared types, limits and ratio-slice helper for the PLL clock-enable generator
package pll_ce_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;
  localparam int MAX_CH = 8;
  localparam int MAX_W = 32;
  function automatic logic [MAX_W-1:0] ch_slice(input logic [MAX_CH*MAX_W-1:0] v, input int i, input int w);
    return MAX_W'(v >> (i * w)) & ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction
endpackage

// File: rtl/pll_ce_chan.sv
// pll_ce_chan: one fractional-rate accumulator producing a registered clock-enable strobe
// Ports: clk, rst_n (async active-low), en (accumulate, else hold phase at 0),
//        clr (force phase to 0, wins over en), num/den (rate num/den), ce (strobe out)
module pll_ce_chan #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  output logic             ce
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] s;
  logic hit;
  assign s = {1'b0, acc} + {1'b0, num};
  assign hit = s >= {1'b0, den};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      ce <= 1'b0;
    end else if (clr || !en) begin
      acc <= '0;
      ce <= 1'b0;
    end else begin
      acc <= hit ? ACC_W'(s - {1'b0, den}) : s[ACC_W-1:0];
      ce <= hit;
    end
endmodule

// File: rtl/pll_ce_gen.sv
// pll_ce_gen: PLL lock sequencer plus NUM_CH fractional clock-enable generators on refclk
// Ports: refclk, rst_n (async active-low), pll_locked (raw, async), ch_en (per channel),
//        sync_clr (realign all phases), ce (strobes), core_rst_n (core reset), run (RUN state)
// Option PLL_CE_RUNTIME_CFG_EN adds cfg_we/cfg_ch/cfg_num/cfg_den for runtime ratio writes.
module pll_ce_gen import pll_ce_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int ACC_W = 16,
  parameter logic [NUM_CH*ACC_W-1:0] CH_NUM = {16'd1, 16'd1},
  parameter logic [NUM_CH*ACC_W-1:0] CH_DEN = {16'd1, 16'd4},
  parameter int LOCK_HOLD = 1024,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
`ifdef PLL_CE_RUNTIME_CFG_EN
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
`endif
  output logic [NUM_CH-1:0] ce,
  output logic              core_rst_n,
  output logic              run
);
  localparam int CNT_W = $clog2(LOCK_HOLD + 1);
  localparam logic [MAX_CH*MAX_W-1:0] NUM_PAD = (MAX_CH*MAX_W)'(CH_NUM);
  localparam logic [MAX_CH*MAX_W-1:0] DEN_PAD = (MAX_CH*MAX_W)'(CH_DEN);
  state_t state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  logic s1, lk, active;
  always_comb begin
    nstate = state == WAIT_LOCK ? (lk ? HOLD : WAIT_LOCK) :
             !lk ? WAIT_LOCK :
             (state == HOLD && cnt == CNT_W'(LOCK_HOLD - 1)) ? RUN : state;
    ncnt = (state == HOLD && nstate == HOLD) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      lk <= 1'b0;
      state <= WAIT_LOCK;
      cnt <= '0;
      run <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      s1 <= pll_locked;
      lk <= s1;
      state <= nstate;
      cnt <= ncnt;
      run <= nstate == RUN;
      core_rst_n <= nstate == RUN;
    end
  // losing lock in RUN clears every channel in the same edge that leaves RUN
  assign active = state == RUN && lk;
`ifdef PLL_CE_RUNTIME_CFG_EN
  logic cfg_ok;
  assign cfg_ok = cfg_we && cfg_den != '0 && cfg_num <= cfg_den && int'(cfg_ch) < NUM_CH;
`endif
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] num_i, den_i;
    logic wr;
`ifdef PLL_CE_RUNTIME_CFG_EN
    assign wr = cfg_ok && cfg_ch == CH_W'(i);
    always_ff @(posedge refclk or negedge rst_n)
      if (!rst_n) begin
        num_i <= ACC_W'(ch_slice(NUM_PAD, i, ACC_W));
        den_i <= ACC_W'(ch_slice(DEN_PAD, i, ACC_W));
      end else if (wr) begin
        num_i <= cfg_num;
        den_i <= cfg_den;
      end
`else
    assign wr = 1'b0;
    assign num_i = ACC_W'(ch_slice(NUM_PAD, i, ACC_W));
    assign den_i = ACC_W'(ch_slice(DEN_PAD, i, ACC_W));
`endif
    pll_ce_chan #(.ACC_W(ACC_W)) u_chan (
      .clk  (refclk),
      .rst_n(rst_n),
      .en   (active && ch_en[i]),
      .clr  (sync_clr || wr),
      .num  (num_i),
      .den  (den_i),
      .ce   (ce[i])
    );
  end
endmodule

// File: tb/tb_pll_ce_gen.sv
// tb_pll_ce_gen: self-checking bench with a cycle-level behavioural model of pll_ce_gen
module tb_pll_ce_gen;
  localparam int LH = 8;
  logic refclk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_locked = 1'b0;
  logic sync_clr = 1'b0;
  logic [2:0] ch_en = 3'b111;
  logic [2:0] ce;
  logic core_rst_n, run;
`ifdef PLL_CE_RUNTIME_CFG_EN
  logic cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [15:0] cfg_num = '0;
  logic [15:0] cfg_den = '0;
`endif
  always #5 refclk = ~refclk;
  pll_ce_gen #(
    .NUM_CH(3), .ACC_W(16),
    .CH_NUM({16'd24, 16'd1, 16'd1}),
    .CH_DEN({16'd25, 16'd1, 16'd4}),
    .LOCK_HOLD(LH)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .ch_en(ch_en), .sync_clr(sync_clr),
`ifdef PLL_CE_RUNTIME_CFG_EN
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_num(cfg_num), .cfg_den(cfg_den),
`endif
    .ce(ce), .core_rst_n(core_rst_n), .run(run)
  );
  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: run after an edge iff lk has been seen high on the last LH+1 edges;
  // channel pulses when floor(k*num/den) steps, k = accumulation edges since phase origin
  int h0 = 0, h1 = 0, streak = 0;
  bit m_run = 1'b0;
  bit [2:0] m_ce = '0;
  longint k[3] = '{0, 0, 0};
  longint mn[3] = '{1, 1, 24};
  longint md[3] = '{4, 1, 25};
  initial forever begin
    @(posedge refclk or negedge rst_n);
    if (!rst_n) begin
      h0 = 0; h1 = 0; streak = 0; m_run = 1'b0; m_ce = '0;
      for (int i = 0; i < 3; i++) k[i] = 0;
    end else begin
      int lk_s;
      bit wr;
      lk_s = h1; h1 = h0; h0 = int'(pll_locked);
      wr = 1'b0;
`ifdef PLL_CE_RUNTIME_CFG_EN
      wr = cfg_we && cfg_den != 0 && cfg_num <= cfg_den && cfg_ch < 3;
`endif
      for (int i = 0; i < 3; i++) begin
`ifdef PLL_CE_RUNTIME_CFG_EN
        if (m_run && lk_s == 1 && ch_en[i] && !sync_clr && !(wr && int'(cfg_ch) == i)) begin
`else
        if (m_run && lk_s == 1 && ch_en[i] && !sync_clr && !wr) begin
`endif
          k[i]++;
          m_ce[i] = (k[i] * mn[i] / md[i]) != ((k[i] - 1) * mn[i] / md[i]);
        end else begin
          k[i] = 0;
          m_ce[i] = 1'b0;
        end
      end
`ifdef PLL_CE_RUNTIME_CFG_EN
      if (wr) begin
        mn[cfg_ch] = longint'(cfg_num);
        md[cfg_ch] = longint'(cfg_den);
      end
`endif
      streak = lk_s == 1 ? streak + 1 : 0;
      m_run = streak >= LH + 1;
    end
  end
  initial forever begin
    @(negedge refclk);
    chk("ce", ce, m_ce);
    chk("run", run, m_run);
    chk("core_rst_n", core_rst_n, m_run);
  end
  task automatic wait_run(input logic val, output int m);
    m = 999;
    for (int i = 1; i <= 60; i++) begin
      @(negedge refclk);
      if (run === val) begin
        m = i;
        break;
      end
    end
  endtask
  task automatic wait_ce0(output int m);
    m = 999;
    for (int i = 1; i <= 40; i++) begin
      @(negedge refclk);
      if (ce[0] === 1'b1) begin
        m = i;
        break;
      end
    end
  endtask
  initial begin
    int m, n0, n1, n2, idle, maxidle;
    rst_n = 1'b0;
    repeat (3) @(negedge refclk);
    chk("reset_ce", ce, 0);
    chk("reset_run", run, 0);
    chk("reset_core_rst_n", core_rst_n, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge refclk);
    chk("prelock_run", run, 0);
    pll_locked = 1'b1;
    wait_run(1'b1, m);
    chk("lock_latency", m, 11);
    n0 = 0; n1 = 0; n2 = 0; idle = 0; maxidle = 0;
    for (int c = 1; c <= 250; c++) begin
      @(negedge refclk);
      if (c <= 40) begin
        n0 += int'(ce[0]);
        n1 += int'(ce[1]);
      end
      n2 += int'(ce[2]);
      idle = ce[2] ? 0 : idle + 1;
      if (idle > maxidle) maxidle = idle;
    end
    chk("ch0_pulses_40", n0, 10);
    chk("ch1_pulses_40", n1, 40);
    chk("ch2_pulses_250", n2, 240);
    chk("ch2_max_idle", maxidle, 1);
    sync_clr = 1'b1;
    @(negedge refclk);
    sync_clr = 1'b0;
    wait_ce0(m);
    chk("sync_clr_phase", m, 4);
    ch_en = 3'b110;
    n0 = 0;
    repeat (5) begin
      @(negedge refclk);
      n0 += int'(ce[0]);
    end
    chk("disabled_pulses", n0, 0);
    ch_en = 3'b111;
    wait_ce0(m);
    chk("reenable_phase", m, 4);
`ifdef PLL_CE_RUNTIME_CFG_EN
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_num = 16'd1; cfg_den = 16'd2;
    @(negedge refclk);
    cfg_we = 1'b0;
    n0 = 0;
    repeat (10) begin
      @(negedge refclk);
      n0 += int'(ce[0]);
    end
    chk("cfg_half_pulses", n0, 5);
    cfg_we = 1'b1; cfg_den = 16'd0;
    @(negedge refclk);
    cfg_we = 1'b0;
    n0 = 0;
    repeat (10) begin
      @(negedge refclk);
      n0 += int'(ce[0]);
    end
    chk("cfg_den0_ignored", n0, 5);
`endif
    pll_locked = 1'b0;
    wait_run(1'b0, m);
    chk("lock_loss_latency", m, 3);
    pll_locked = 1'b1;
    wait_run(1'b1, m);
    chk("relock_latency", m, 11);
    pll_locked = 1'b0;
    repeat (10) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (6) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    wait_run(1'b1, m);
    chk("hold_glitch_restart", m, 11);
    repeat (3) @(negedge refclk);
    @(posedge refclk);
    #1 chk("pre_reset_ce1", ce[1], 1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_ce", ce, 0);
    chk("async_reset_run", run, 0);
    chk("async_reset_core_rst_n", core_rst_n, 0);
    @(negedge refclk);
    rst_n = 1'b1;
    wait_run(1'b1, m);
    chk("post_reset_relock", m, 11);
    repeat (2) @(negedge refclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pll_ce_gen.md
Name: pll_ce_gen

Overview:
- Parametrised multi-channel clock-enable generator; successor to the fixed two-output PLL wrapper.
- Runs on the single PLL output clock. Produces N fractional-rate CE strobes (e.g. 12 MHz effective from 48 MHz) instead of extra PLL outputs.
- Sequences core reset release from PLL lock: synchronises lock, holds for a programmable settle time, drops everything if lock is lost.
- Sits between the PLL instance and the core top; all core logic uses refclk plus ce[i].

Parameters:
NUM_CH, 2, number of CE channels (1..8)
ACC_W, 16, accumulator and ratio width in bits
CH_NUM, {16'd1,16'd1}, packed NUM_CH*ACC_W per-channel numerators; channel i in bits [i*ACC_W +: ACC_W]
CH_DEN, {16'd1,16'd4}, packed per-channel denominators; required 0 < NUM <= DEN
LOCK_HOLD, 1024, refclk cycles that sync'd lock must stay high before release (>= 1)

Ports:
refclk  in  1  single clock (PLL output)
rst_n  in  1  asynchronous reset, active-low
pll_locked  in  1  raw PLL lock, asynchronous to refclk
ch_en  in  NUM_CH  per-channel enable
sync_clr  in  1  synchronous phase realign of all channels
ce  out  NUM_CH  registered one-cycle enable strobes
core_rst_n  out  1  registered core reset, active-low
run  out  1  high while in RUN state

Behaviour:
- Reset values (rst_n low, async): ce=0, core_rst_n=0, run=0, all accumulators=0, hold counter=0, synchroniser=0, state=WAIT_LOCK.
- Lock synchroniser: 2-flop on pll_locked; the second flop (lk) drives the FSM.
- FSM WAIT_LOCK: counter=0. On lk=1, go to HOLD.
- FSM HOLD: counter increments each cycle.
  - lk=0 -> WAIT_LOCK, counter cleared.
  - Counter==LOCK_HOLD-1 with lk=1 -> RUN.
- FSM RUN: run=1 and core_rst_n=1, both registered, visible from the first RUN cycle.
  - lk=0 -> WAIT_LOCK next cycle.
  - In that cycle run, core_rst_n and ce go 0 and all accumulators clear.
- Channel i, while in RUN with ch_en[i]=1:
  - s = acc + NUM, computed at ACC_W+1 bits (no overflow).
  - If s >= DEN: acc <= s - DEN and ce[i] <= 1. Otherwise acc <= s and ce[i] <= 0.
- Rate is exactly NUM/DEN of refclk. NUM==DEN gives ce high every RUN cycle.
- RUN entry cycle is cycle 0 and acc starts at 0. With NUM=1, DEN=4, ce is high in cycles 4, 8, 12, ...
- ch_en[i]=0: acc[i] forced to 0 and ce[i]=0. Re-enabling restarts the phase from 0.
- sync_clr=1 in RUN: all acc forced to 0 and all ce=0 in the next cycle, so channels realign. sync_clr has priority over accumulation.
- sync_clr or ch_en outside RUN: no effect; acc is already held at 0.
- ce is never asserted outside RUN.

Optional Feature:
- Macro: PLL_CE_RUNTIME_CFG_EN.
- When defined, these ports are added:
  - cfg_we (1)
  - cfg_ch ($clog2(NUM_CH), min 1)
  - cfg_num (ACC_W)
  - cfg_den (ACC_W)
- cfg_we=1 loads per-channel NUM/DEN registers, which reset to CH_NUM/CH_DEN.
  - The write also clears that channel's acc. The new ratio applies from the next cycle.
  - Writes with cfg_den=0, cfg_num>cfg_den, or cfg_ch>=NUM_CH are ignored.
- When undefined: ratios are the constant parameters and there are no cfg ports.

Decomposition:
- Package pll_ce_pkg holds:
  - FSM state enum (WAIT_LOCK, HOLD, RUN)
  - MAX_CH=8
  - helper function extracting a channel slice from a packed ratio vector
- One sub-module, pll_ce_chan: a single fractional accumulator (en, clr, num, den -> ce), instantiated NUM_CH times by generate.
- The FSM and the synchroniser stay in the top level.

Test Plan:
- LOCK_HOLD=8; assert pll_locked at t0 -> core_rst_n and run rise exactly 2+1+8 cycles later (2 sync, 1 WAIT_LOCK->HOLD, 8 HOLD); no ce before that.
- Defaults (ch0 1/4, ch1 1/1), RUN for 40 cycles -> ch0 pulses in cycles 4, 8, ... 40 (10 pulses); ch1 high all 40 cycles.
- Ratio 24/25 over 250 cycles -> exactly 240 ce pulses, never two consecutive idle cycles.
- pll_locked glitch low for 1 cycle during HOLD -> counter restarts; low for 3 cycles during RUN -> run, core_rst_n and ce drop; full LOCK_HOLD re-sequenced.
- sync_clr pulse mid-RUN with ch0 at acc=2 -> ch0 next pulses 4 cycles after clear; ch_en[0] low for 5 cycles -> no ch0 pulses, restart from phase 0.
- rst_n low asynchronously mid-RUN (between edges) -> all outputs 0 immediately; release -> WAIT_LOCK. With PLL_CE_RUNTIME_CFG_EN: write ch0 = 1/2 -> pulses every 2 cycles; write den=0 -> ignored.
